// File: rtl/spi_file_loader.sv
// spi_file_loader: SPI-slave file-download receiver for the MiST I/O link.
// The ARM SPI bus is oversampled in the clk_72 domain. Command frames on
// SS2 select index, start/stop and data transfer. Received data bytes are
// presented as an (address, data, one-cycle strobe) write stream.
// Optional feature macro: SPI_FILE_LOADER_DIRECT_EN. When it is defined,
// SS4 carries raw data bytes with no command byte while a download is active.
module spi_file_loader #(
  parameter int ADDR_W     = 25,
  parameter int START_ADDR = 0
) (
  input  logic              clk_72,
  input  logic              reset,
  input  logic              SPI_SCK,
  input  logic              SPI_SS2,
  input  logic              SPI_SS4,
  input  logic              SPI_DI,
  output logic              SPI_DO,
  output logic              ioctl_download,
  output logic [7:0]        ioctl_index,
  output logic              ioctl_wr,
  output logic [ADDR_W-1:0] ioctl_addr,
  output logic [7:0]        ioctl_dout
);

  localparam logic [ADDR_W-1:0] START_C = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] ONE_C   = ADDR_W'(1);

  localparam logic [7:0] CMD_FILE_INDEX  = 8'h55;
  localparam logic [7:0] CMD_FILE_TX     = 8'h53;
  localparam logic [7:0] CMD_FILE_TX_DAT = 8'h54;

  // Synchronizers. sck_q[2] is the history stage used for edge detection.
  logic [2:0] sck_q, sck_d;
  logic [1:0] ss2_q, ss2_d;
  logic [1:0] ss4_q, ss4_d;
  logic [1:0] di_q, di_d;

  logic [7:0]        shift_q, shift_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;   // saturates at 2 (0, 1, >=2)
  logic [7:0]        cmd_q, cmd_d;
  logic              download_q, download_d;
  logic [7:0]        index_q, index_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        dout_q, dout_d;

  logic       sck_rise_s;
  logic       ss2_s;
  logic       di_s;
  logic       direct_s;
  logic       shift_en_s;
  logic [7:0] new_byte_s;

  assign sck_rise_s = sck_q[1] & ~sck_q[2];
  assign ss2_s      = ss2_q[1];
  assign di_s       = di_q[1];
  assign new_byte_s = {shift_q[6:0], di_s};

`ifdef SPI_FILE_LOADER_DIRECT_EN
  // Direct mode: SS4 low with SS2 high; SS2 always wins when both are low.
  assign direct_s = ss2_s & ~ss4_q[1];
  assign SPI_DO   = (SPI_SS2 & SPI_SS4) ? 1'bz : 1'b0;
`else
  logic unused_ss4_s;
  assign unused_ss4_s = &{1'b0, ss4_q[1]};
  assign direct_s     = 1'b0;
  assign SPI_DO       = SPI_SS2 ? 1'bz : 1'b0;
`endif

  assign shift_en_s = ~ss2_s | direct_s;

  // Next-state logic: synchronizers, shifter, command decode and write stream.
  always_comb begin
    sck_d      = {sck_q[1:0], SPI_SCK};
    ss2_d      = {ss2_q[0], SPI_SS2};
    ss4_d      = {ss4_q[0], SPI_SS4};
    di_d       = {di_q[0], SPI_DI};
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    cmd_d      = cmd_q;
    download_d = download_q;
    index_d    = index_q;
    wr_d       = 1'b0;
    dout_d     = dout_q;
    // The address advances on the cycle after each write strobe.
    addr_d     = wr_q ? (addr_q + ONE_C) : addr_q;

    if (ss2_s) begin
      byte_cnt_d = 2'd0;
    end else begin
      byte_cnt_d = byte_cnt_q;
    end

    if (!shift_en_s) begin
      bit_cnt_d = 3'd0;
    end else if (sck_rise_s) begin
      shift_d   = new_byte_s;
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        if (direct_s) begin
          if (download_q) begin
            wr_d   = 1'b1;
            dout_d = new_byte_s;
          end else begin
            wr_d   = 1'b0;
          end
        end else begin
          if (byte_cnt_q != 2'd2) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end else begin
            byte_cnt_d = byte_cnt_q;
          end
          if (byte_cnt_q == 2'd0) begin
            cmd_d = new_byte_s;
          end else begin
            case (cmd_q)
              CMD_FILE_INDEX: begin
                if (byte_cnt_q == 2'd1) begin
                  index_d = new_byte_s;
                end else begin
                  index_d = index_q;
                end
              end
              CMD_FILE_TX: begin
                if (byte_cnt_q == 2'd1) begin
                  if (new_byte_s != 8'h00) begin
                    download_d = 1'b1;
                    addr_d     = START_C;
                  end else begin
                    download_d = 1'b0;
                  end
                end else begin
                  download_d = download_q;
                end
              end
              CMD_FILE_TX_DAT: begin
                if (download_q) begin
                  wr_d   = 1'b1;
                  dout_d = new_byte_s;
                end else begin
                  wr_d   = 1'b0;
                end
              end
              default: begin
                cmd_d = cmd_q;
              end
            endcase
          end
        end
      end else begin
        byte_cnt_d = byte_cnt_q;
      end
    end else begin
      bit_cnt_d = bit_cnt_q;
    end
  end

  // State registers with synchronous reset; selects idle high on reset.
  always_ff @(posedge clk_72) begin
    if (reset) begin
      sck_q      <= 3'b000;
      ss2_q      <= 2'b11;
      ss4_q      <= 2'b11;
      di_q       <= 2'b00;
      shift_q    <= 8'h00;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 2'd0;
      cmd_q      <= 8'h00;
      download_q <= 1'b0;
      index_q    <= 8'h00;
      wr_q       <= 1'b0;
      addr_q     <= START_C;
      dout_q     <= 8'h00;
    end else begin
      sck_q      <= sck_d;
      ss2_q      <= ss2_d;
      ss4_q      <= ss4_d;
      di_q       <= di_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      cmd_q      <= cmd_d;
      download_q <= download_d;
      index_q    <= index_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
    end
  end

  assign ioctl_download = download_q;
  assign ioctl_index    = index_q;
  assign ioctl_wr       = wr_q;
  assign ioctl_addr     = addr_q;
  assign ioctl_dout     = dout_q;

endmodule

// File: tb/tb_spi_file_loader.sv
// Scoreboard bench for spi_file_loader: expected writes are queued as stimulus
// is issued, and a monitor pops and compares on every ioctl_wr strobe.
module tb_spi_file_loader;

  localparam int ADDR_W = 25;

  logic              clk_72 = 1'b0;
  logic              reset  = 1'b1;
  logic              SPI_SCK = 1'b0;
  logic              SPI_SS2 = 1'b1;
  logic              SPI_SS4 = 1'b1;
  logic              SPI_DI  = 1'b0;
  logic              SPI_DO;
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [7:0]        ioctl_dout;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;
  wr_t exp_q[$];

  spi_file_loader #(.ADDR_W(ADDR_W), .START_ADDR(0)) dut (
    .clk_72         (clk_72),
    .reset          (reset),
    .SPI_SCK        (SPI_SCK),
    .SPI_SS2        (SPI_SS2),
    .SPI_SS4        (SPI_SS4),
    .SPI_DI         (SPI_DI),
    .SPI_DO         (SPI_DO),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout)
  );

  always #7 clk_72 = ~clk_72;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest queued expectation.
  always @(negedge clk_72) begin
    if (!reset && ioctl_wr) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_wr: got addr=0x%0h dout=0x%0h, none expected",
                 ioctl_addr, ioctl_dout);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (ioctl_addr !== e.addr || ioctl_dout !== e.data) begin
          n_fail++;
          $display("FAIL wr_data: got addr=0x%0h dout=0x%0h expected addr=0x%0h dout=0x%0h",
                   ioctl_addr, ioctl_dout, e.addr, e.data);
        end
      end
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk_72);
  endtask

  // Send the top n bits of b, MSB first, SCK period = 8 clk_72 cycles.
  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      SPI_DI = b[7-i];
      clks(4);
      SPI_SCK = 1'b1;
      clks(4);
      SPI_SCK = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] b);
    spi_bits(b, 8);
  endtask

  task automatic ss2_low();
    SPI_SS2 = 1'b0;
    clks(4);
  endtask

  task automatic ss2_high();
    clks(4);
    SPI_SS2 = 1'b1;
    clks(8);
  endtask

  task automatic frame2(input logic [7:0] b0, input logic [7:0] b1);
    ss2_low();
    spi_byte(b0);
    spi_byte(b1);
    ss2_high();
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clks(4);
    reset = 1'b0;
    clks(2);
    chk("rst_download", {31'd0, ioctl_download}, 32'd0);
    chk("rst_index", {24'd0, ioctl_index}, 32'd0);
    chk("rst_addr", 32'(ioctl_addr), 32'd0);
    chk("rst_dout", {24'd0, ioctl_dout}, 32'd0);
    chk("rst_wr", {31'd0, ioctl_wr}, 32'd0);

    // Index command; the third byte must be ignored.
    ss2_low();
    chk("spi_do_selected", {31'd0, SPI_DO}, 32'd0);
    spi_byte(8'h55);
    spi_byte(8'h42);
    spi_byte(8'h99);
    ss2_high();
    chk("index_loaded", {24'd0, ioctl_index}, 32'h42);
    chk("index_no_dl", {31'd0, ioctl_download}, 32'd0);

    // Start download, then three data bytes.
    frame2(8'h53, 8'h01);
    chk("dl_started", {31'd0, ioctl_download}, 32'd1);
    push(25'd0, 8'hAA);
    push(25'd1, 8'hBB);
    push(25'd2, 8'hCC);
    ss2_low();
    spi_byte(8'h54);
    spi_byte(8'hAA);
    spi_byte(8'hBB);
    spi_byte(8'hCC);
    ss2_high();
    chk("addr_after_3", 32'(ioctl_addr), 32'd3);

    // Unknown command frame with data: ignored.
    frame2(8'h12, 8'h34);
    chk("unknown_cmd_addr", 32'(ioctl_addr), 32'd3);

    // Partial data byte discarded, then a fresh data frame.
    ss2_low();
    spi_byte(8'h54);
    spi_bits(8'hFF, 5);
    ss2_high();
    push(25'd3, 8'h77);
    frame2(8'h54, 8'h77);
    chk("addr_after_partial", 32'(ioctl_addr), 32'd4);

    // Restart while downloading goes back to address 0.
    frame2(8'h53, 8'h02);
    chk("restart_addr", 32'(ioctl_addr), 32'd0);
    chk("restart_dl", {31'd0, ioctl_download}, 32'd1);

    // Stop download; subsequent data is ignored.
    frame2(8'h53, 8'h00);
    chk("dl_stopped", {31'd0, ioctl_download}, 32'd0);
    frame2(8'h54, 8'h11);
    chk("no_wr_addr", 32'(ioctl_addr), 32'd0);

    // Reset in the middle of a download byte.
    frame2(8'h53, 8'h01);
    push(25'd0, 8'h10);
    ss2_low();
    spi_byte(8'h54);
    spi_byte(8'h10);
    spi_bits(8'hF0, 3);
    reset = 1'b1;
    clks(1);
    reset = 1'b0;
    clks(1);
    chk("mid_rst_download", {31'd0, ioctl_download}, 32'd0);
    chk("mid_rst_index", {24'd0, ioctl_index}, 32'd0);
    chk("mid_rst_addr", 32'(ioctl_addr), 32'd0);
    chk("mid_rst_dout", {24'd0, ioctl_dout}, 32'd0);
    chk("mid_rst_wr", {31'd0, ioctl_wr}, 32'd0);
    ss2_high();
    frame2(8'h53, 8'h01);
    push(25'd0, 8'h5A);
    frame2(8'h54, 8'h5A);
    chk("after_rst_addr", 32'(ioctl_addr), 32'd1);

    // Direct-data mode over SS4 after a fresh start.
    frame2(8'h53, 8'h01);
`ifdef SPI_FILE_LOADER_DIRECT_EN
    push(25'd0, 8'h01);
    push(25'd1, 8'h02);
`endif
    SPI_SS4 = 1'b0;
    clks(4);
    spi_byte(8'h01);
    spi_byte(8'h02);
    clks(4);
    SPI_SS4 = 1'b1;
    clks(8);
`ifdef SPI_FILE_LOADER_DIRECT_EN
    chk("direct_addr", 32'(ioctl_addr), 32'd2);
`else
    chk("direct_ignored_addr", 32'(ioctl_addr), 32'd0);
`endif

    clks(8);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
